// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//
// Synchronous valid/ready FIFO with DEPTH entries of W_DATA bits.
// Storage is a plain register array addressed by wrap-around pointers that
// carry one extra MSB so a full queue can be told apart from an empty one.
// Occupancy is kept in its own register so level_o and afull_o come straight
// from flops.
//
// Optional build macro:
//   STREAM_FIFO_BYPASS_EN - first-word bypass. When the queue is empty and a
//                           word is offered, it is presented on the output in
//                           the same cycle. If the consumer takes it, no
//                           write happens. If not, it is written normally.
//                           Undefined by default. Without it, the output has
//                           no combinational path from the input side.
//
// Parameters:
//   W_DATA        data width in bits
//   DEPTH         entry count; power of two, >= 2
//   AFULL_THRESH  occupancy at or above which afull_o asserts (1..DEPTH)
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_i        synchronous active-high reset (clears pointers and level)
//   in_data_i    write data
//   in_valid_i   write request
//   in_ready_o   space available (never depends on out_ready_i)
//   out_data_o   head-of-queue data
//   out_valid_o  queue non-empty (or bypass active)
//   out_ready_i  consumer accepts
//   level_o      current occupancy, 0..DEPTH
//   afull_o      level_o >= AFULL_THRESH
// -----------------------------------------------------------------------------
module stream_fifo #(
  parameter int unsigned W_DATA       = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [W_DATA-1:0]          in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [W_DATA-1:0]          out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       afull_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [PW-1:0] LVL_FULL  = PW'(DEPTH);
  localparam logic [PW-1:0] LVL_AFULL = PW'(AFULL_THRESH);

  logic [W_DATA-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q,  wptr_d;
  logic [PW-1:0] rptr_q,  rptr_d;
  logic [PW-1:0] level_q, level_d;

  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;

  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;
  logic bypass;

  assign waddr = wptr_q[AW-1:0];
  assign raddr = rptr_q[AW-1:0];

  // Handshake and output side.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = mem_q[raddr];
    bypass      = 1'b0;

    // While reset is high no handshake may complete.
    in_ready_o  = !rst_i && (level_q != LVL_FULL);

`ifdef STREAM_FIFO_BYPASS_EN
    bypass      = !rst_i && (level_q == '0) && in_valid_i;
    out_valid_o = (!rst_i && (level_q != '0)) || bypass;
    if (bypass) begin
      out_data_o = in_data_i;
    end
`else
    out_valid_o = !rst_i && (level_q != '0);
`endif
  end

  // Storage and pointer next-state.
  always_comb begin
    push    = in_valid_i && in_ready_o;
    pop     = out_valid_o && out_ready_i;
    wr_en   = push;
    rd_en   = pop;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;

    // A bypassed word that the consumer takes in the same cycle never
    // touches the storage: it is neither written nor read.
    if (bypass && out_ready_i) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
    end

    if (wr_en) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (rd_en) begin
      rptr_d = rptr_q + PW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Memory contents are not reset. wr_en is already gated off during reset
  // because in_ready_o is held low.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[waddr] <= in_data_i;
    end
  end

  assign level_o = level_q;
  assign afull_o = (level_q >= LVL_AFULL);

endmodule

// File: tb/tb_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo
//
// Self-checking bench for stream_fifo (W_DATA=32, DEPTH=4, AFULL_THRESH=3).
// A queue-based reference model predicts in_ready/out_valid/out_data/level/
// afull each cycle from the occupancy rules. Directed scenarios come first,
// followed by 1000 randomly handshaked words.
// -----------------------------------------------------------------------------
module tb_stream_fifo;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned TH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    level;
  logic          afull;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [W-1:0] mq[$];
  int unsigned  n_reads = 0;
  logic [W-1:0] last_pop;
  logic         last_pop_v;

  always #5 clk = ~clk;

  stream_fifo #(
    .W_DATA      (W),
    .DEPTH       (D),
    .AFULL_THRESH(TH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .level_o    (level),
    .afull_o    (afull)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check just after, update the model at
  // the following posedge. acc reports whether the offered word was taken.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                      input logic rs, output logic acc);
    logic byp, e_ir, e_ov;
    logic [W-1:0] e_od;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    #1;
    byp = 1'b0;
`ifdef STREAM_FIFO_BYPASS_EN
    byp = !rs && (mq.size() == 0) && v;
`endif
    e_ir = !rs && (mq.size() != D);
    e_ov = !rs && ((mq.size() != 0) || byp);
    e_od = byp ? d : ((mq.size() != 0) ? mq[0] : '0);
    chk("in_ready",  W'(in_ready),  W'(e_ir));
    chk("out_valid", W'(out_valid), W'(e_ov));
    chk("level",     W'(level),     W'(mq.size()));
    chk("afull",     W'(afull),     W'(mq.size() >= TH));
    if (e_ov) chk("out_data", out_data, e_od);
    @(posedge clk);
    acc = 1'b0;
    last_pop_v = 1'b0;
    if (rs) begin
      mq.delete();
    end else begin
      acc = v && e_ir;
      if (byp && r) begin
        last_pop = d;
        last_pop_v = 1'b1;
      end else begin
        if (e_ov && r) begin
          last_pop = mq.pop_front();
          last_pop_v = 1'b1;
          n_reads++;
        end
        if (acc) mq.push_back(d);
      end
    end
  endtask

  initial begin
    logic acc;
    logic [W-1:0] cur_d;
    logic cur_v;
    int unsigned pushed;
    int unsigned cycles;
    logic [W-1:0] words[5];

    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    words[3] = 32'h44; words[4] = 32'h55;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst = 1'b1;

    // Reset.
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    #1;
    chk("rst_level",  W'(level),     W'(0));
    chk("rst_afull",  W'(afull),     W'(0));
    chk("rst_oval",   W'(out_valid), W'(0));

    // Fill to full with the consumer stalled; fifth word refused.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, words[i], 1'b0, 1'b0, acc);
      chk("fill_acc", W'(acc), W'(i < 4));
      #1;
      chk("fill_afull", W'(afull), W'(i >= 2));
    end
    chk("full_level", W'(level), W'(4));
    chk("full_iready", W'(in_ready), W'(0));

    // Full: pop with a word offered. No push this cycle; next cycle it goes in.
    step(1'b1, 32'h55, 1'b1, 1'b0, acc);
    chk("full_pop_noacc", W'(acc), W'(0));
    chk("full_pop_word", last_pop, 32'h11);
    step(1'b1, 32'h55, 1'b0, 1'b0, acc);
    chk("refill_acc", W'(acc), W'(1));
    #1;
    chk("refill_level", W'(level), W'(4));

    // Drain to level 3, then reset mid-operation.
    step(1'b0, '0, 1'b1, 1'b0, acc);
    #1;
    chk("pre_rst_level", W'(level), W'(3));
    step(1'b1, 32'hFF, 1'b1, 1'b1, acc);
    #1;
    chk("mid_rst_level", W'(level), W'(0));
    chk("mid_rst_oval",  W'(out_valid), W'(0));
    step(1'b1, 32'hA5, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("post_rst_first", last_pop, 32'hA5);

    // Empty queue, push with consumer ready.
    step(1'b1, 32'hDEAD, 1'b1, 1'b0, acc);
`ifdef STREAM_FIFO_BYPASS_EN
    chk("byp_same_cycle", W'(last_pop_v), W'(1));
    chk("byp_word", last_pop, 32'hDEAD);
    #1;
    chk("byp_level", W'(level), W'(0));
`else
    chk("nobyp_no_pop", W'(last_pop_v), W'(0));
    #1;
    chk("nobyp_level", W'(level), W'(1));
    step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("nobyp_word", last_pop, 32'hDEAD);
`endif
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Random traffic, 1000 words; offered data held until accepted.
    pushed = 0;
    cycles = 0;
    n_reads = 0;
    cur_v = 1'b0;
    cur_d = '0;
    while ((pushed < 1000 || mq.size() != 0) && cycles < 20000) begin
      if (!cur_v && pushed < 1000 && $urandom_range(0, 3) != 0) begin
        cur_v = 1'b1;
        cur_d = $urandom;
      end
      step(cur_v, cur_d, ($urandom_range(0, 3) != 0), 1'b0, acc);
      if (acc) begin
        cur_v = 1'b0;
        pushed++;
      end
      cycles++;
    end
    chk("rand_done", W'(cycles < 20000), W'(1));
    chk("rand_drained", W'(mq.size()), W'(0));
`ifndef STREAM_FIFO_BYPASS_EN
    chk("ptr_wraps", W'(n_reads / (2 * D) >= 100), W'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
